// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type and default latencies.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    function automatic logic mdu_is_arith(input logic [3:0] code);
        return (code == MDU_MULT) || (code == MDU_MULTU) ||
               (code == MDU_DIV)  || (code == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers. Results are
// computed at accept, held pending, and committed when the latency expires.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    mdu_state_t   state;
    logic [15:0]  cnt;
    logic [31:0]  hi_q, lo_q;
    logic [31:0]  pend_hi, pend_lo;
    logic         pend_wr;
    logic         busy_q;

    logic signed [63:0] smul;
    logic [63:0]        umul;
    logic signed [31:0] sq, sr;
    logic [31:0]        uq, ur;
    logic [31:0]        calc_hi, calc_lo;
    logic               calc_wr;

    // Behavioural arithmetic for the operands on the bus; only sampled at accept.
    // The most-negative / -1 quotient overflows 32 bits, so it is pinned explicitly.
    always_comb begin
        smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        umul = {32'd0, a} * {32'd0, b};
        sq = '0;
        sr = '0;
        uq = '0;
        ur = '0;
        if (b != 32'd0) begin
            uq = a / b;
            ur = a % b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                sq = 32'sh8000_0000;
                sr = '0;
            end else begin
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
            end
        end
        calc_hi = '0;
        calc_lo = '0;
        calc_wr = 1'b0;
        case (op)
            MDU_MULT:  begin calc_hi = smul[63:32]; calc_lo = smul[31:0]; calc_wr = 1'b1; end
            MDU_MULTU: begin calc_hi = umul[63:32]; calc_lo = umul[31:0]; calc_wr = 1'b1; end
            MDU_DIV:   begin calc_hi = sr; calc_lo = sq; calc_wr = (b != 32'd0); end
            MDU_DIVU:  begin calc_hi = ur; calc_lo = uq; calc_wr = (b != 32'd0); end
            default:   ;
        endcase
    end

    // Control FSM: accept in IDLE, count down in RUN, commit pending HI/LO on expiry.
    // A divide by zero still occupies the unit but leaves HI/LO untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && mdu_is_arith(op)) begin
                        pend_hi <= calc_hi;
                        pend_lo <= calc_lo;
                        pend_wr <= calc_wr;
                        cnt     <= (op == MDU_MULT || op == MDU_MULTU) ?
                                   16'(MUL_CYCLES) : 16'(DIV_CYCLES);
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end else if (op == MDU_MTHI) begin
                        hi_q <= a;
                    end else if (op == MDU_MTLO) begin
                        lo_q <= a;
                    end
                end
                RUN: begin
                    if (cnt <= 16'd1) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        case (op)
            MDU_MFHI: out = hi_q;
            MDU_MFLO: out = lo_q;
            default:  out = '0;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// requests compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo, out;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_hi, exp_lo;

    mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of a completed request, from plain 64-bit arithmetic.
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sp, q, r;
        logic [63:0] up;
        case (o)
            4'd1: begin sp = longint'($signed(x)) * longint'($signed(y));
                        exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
            4'd2: begin up = 64'(x) * 64'(y); exp_hi = up[63:32]; exp_lo = up[31:0]; end
            4'd3: if (y != 0) begin
                      q = longint'($signed(x)) / longint'($signed(y));
                      r = longint'($signed(x)) % longint'($signed(y));
                      exp_lo = q[31:0]; exp_hi = r[31:0];
                  end
            4'd4: if (y != 0) begin exp_lo = x / y; exp_hi = x % y; end
            default: ;
        endcase
    endtask

    // Issue one request, drive noise while busy, then check latency and result.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] noise, input string tag);
        int n, lat;
        lat = (o == 4'd1 || o == 4'd2) ? 5 : 10;
        start = 1'b1; op = o; a = x; b = y;
        step();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            start = 1'($urandom_range(0, 1));
            op = noise; a = $urandom; b = $urandom;
            #1;
            checks++;
            if (hi !== exp_hi || lo !== exp_lo) begin
                failures++;
                $display("[TB] FAIL %s early_commit: hi=%h lo=%h expected hi=%h lo=%h",
                         tag, hi, lo, exp_hi, exp_lo);
            end
            if (noise == 4'd5 || noise == 4'd6) begin
                checks++;
                if (out !== ((noise == 4'd5) ? exp_hi : exp_lo)) begin
                    failures++;
                    $display("[TB] FAIL %s out_in_run: got %h expected %h", tag, out,
                             (noise == 4'd5) ? exp_hi : exp_lo);
                end
            end
            step();
            n++;
        end
        start = 1'b0; op = 4'd0;
        checks++;
        if (n != lat) begin
            failures++;
            $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", tag, n, lat);
        end
        model(o, x, y);
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            failures++;
            $display("[TB] FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h",
                     tag, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 4'd7; a = 32'hDEAD_BEEF; b = 32'd1;
        step();
        step();
        exp_hi = 32'd0; exp_lo = 32'd0;
        op = 4'd5;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: busy=%b hi=%h lo=%h out=%h expected 0", busy, hi, lo, out);
        end
        reset = 1'b0;
        do_op(4'd1, 32'd6, 32'd7, 4'd0, "first_after_reset");
    endtask

    task automatic test_mult();
        do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 4'd0, "mult_neg");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            failures++;
            $display("[TB] FAIL mult_neg_const: hi=%h lo=%h expected FFFFFFFF FFFFFFFA", hi, lo);
        end
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 4'd5, "multu");
        checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            failures++;
            $display("[TB] FAIL multu_const: hi=%h lo=%h expected 00000001 FFFFFFFE", hi, lo);
        end
    endtask

    task automatic test_div();
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 4'd6, "div_neg");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            failures++;
            $display("[TB] FAIL div_neg_const: hi=%h lo=%h expected FFFFFFFF FFFFFFFD", hi, lo);
        end
        do_op(4'd4, 32'd7, 32'd0, 4'd8, "divu_by_zero");
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, "div_overflow");
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            failures++;
            $display("[TB] FAIL div_overflow_const: hi=%h lo=%h expected 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_move();
        logic [31:0] v;
        start = 1'b0; op = 4'd7; a = 32'h1234_5678;
        step();
        exp_hi = 32'h1234_5678;
        op = 4'd5; #1;
        checks++;
        if (hi !== exp_hi || out !== exp_hi) begin
            failures++;
            $display("[TB] FAIL mthi: hi=%h out=%h expected %h", hi, out, exp_hi);
        end
        op = 4'd6; #1;
        checks++;
        if (out !== exp_lo) begin
            failures++;
            $display("[TB] FAIL mflo_read: got %h expected %h", out, exp_lo);
        end
        v = $urandom;
        start = 1'b1; op = 4'd8; a = v;
        step();
        exp_lo = v;
        op = 4'd6; start = 1'b0; #1;
        checks++;
        if (lo !== exp_lo || out !== exp_lo || hi !== exp_hi) begin
            failures++;
            $display("[TB] FAIL mtlo: lo=%h out=%h hi=%h expected lo=%h hi=%h", lo, out, hi, exp_lo, exp_hi);
        end
        op = 4'd0; #1;
        checks++;
        if (out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL out_none: got %h expected 0", out);
        end
    endtask

    task automatic test_ignore();
        logic [3:0] codes [6] = '{4'd0, 4'd5, 4'd6, 4'd9, 4'd12, 4'd15};
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; op = codes[i]; a = $urandom; b = $urandom;
            step();
            checks++;
            if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
                failures++;
                $display("[TB] FAIL ignore_op%0d: busy=%b hi=%h lo=%h expected 0 %h %h",
                         codes[i], busy, hi, lo, exp_hi, exp_lo);
            end
        end
        start = 1'b0; op = 4'd0;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] x, y;
        x = $urandom; y = $urandom | 32'd1;
        start = 1'b1; op = 4'd3; a = x; b = y;
        step();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            start = (n == 1); op = (n == 1) ? 4'd1 : 4'd0;
            a = $urandom; b = $urandom;
            step();
            n++;
        end
        start = 1'b0; op = 4'd0;
        model(4'd3, x, y);
        checks++;
        if (n != 10 || hi !== exp_hi || lo !== exp_lo) begin
            failures++;
            $display("[TB] FAIL back_to_back: cycles=%0d hi=%h lo=%h expected 10 %h %h",
                     n, hi, lo, exp_hi, exp_lo);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            failures++;
            $display("[TB] FAIL back_to_back_late: busy=%b hi=%h lo=%h expected 0 %h %h",
                     busy, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset_abort();
        start = 1'b1; op = 4'd1; a = 32'hFFFF_FFFE; b = 32'd3;
        step();
        start = 1'b0; op = 4'd0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_abort: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_abort_late: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
    endtask

    task automatic test_random();
        logic [3:0] noises [7] = '{4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 4'd1, 4'd3};
        logic [3:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 16; i++) begin
            o = 4'($urandom_range(1, 4));
            x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 9));
                default: y = $urandom;
            endcase
            do_op(o, x, y, noises[$urandom_range(0, 6)], "random");
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
        exp_hi = '0; exp_lo = '0;
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, meaning the busy duration for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the busy duration for div/divu.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset; clock clk.
REQ-005 SHALL have port start, input, 1, a mult/div request from the EX stage, sampled at posedge.
REQ-006 SHALL have port op, input, 4, operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
REQ-007 SHALL have port a, input, 32, forwarded rs operand.
REQ-008 SHALL have port b, input, 32, forwarded rt operand.
REQ-009 SHALL have port busy, output, 1, high while a mult/div is in flight.
REQ-010 SHALL have port hi, output, 32, architectural HI register.
REQ-011 SHALL have port lo, output, 32, architectural LO register.
REQ-012 SHALL have port out, output, 32, the read result for mfhi/mflo.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; busy=1 exactly in RUN.
REQ-014 SHALL accept a request in IDLE when start=1 and op is in 1..4 at a posedge.
- Operands latched, counter loaded with MUL_CYCLES or DIV_CYCLES, next state RUN.
REQ-015 SHALL ignore start with op outside 1..4 (no state change).
REQ-016 SHALL ignore start in RUN; no queuing.
REQ-017 SHALL decrement the counter every cycle in RUN.
- At the edge where the counter reaches 0: commit the pending HI/LO, go to IDLE.
- busy falls in the same cycle HI/LO show the new values.
- busy is high for exactly N cycles following the accept edge.
REQ-018 SHALL compute mult as the signed 64-bit product of a and b, with HI=[63:32] and LO=[31:0].
REQ-019 SHALL compute multu the same way as mult but unsigned.
REQ-020 SHALL compute div as LO=signed quotient truncated toward zero, HI=remainder carrying the sign of the dividend.
REQ-021 SHALL compute divu as LO=unsigned quotient, HI=unsigned remainder.
REQ-022 SHALL keep HI and LO unchanged on divide by zero (b=0), while still asserting busy for DIV_CYCLES.
REQ-023 SHALL produce LO=0x80000000 and HI=0 for div of 0x80000000 by 0xFFFFFFFF.
REQ-024 SHALL write HI<=a at posedge for mthi when in IDLE.
- This does not depend on start.
- mthi is ignored in RUN (the pipeline holds it stalled).
REQ-025 SHALL apply mtlo to LO under the same rules as REQ-024.
REQ-026 SHALL drive out combinationally as hi when op=5, lo when op=6, and 0 otherwise.
REQ-027 SHALL let out reflect committed registers only; pending results are never visible before commit.
REQ-028 SHALL not change HI/LO, busy or the FSM state in response to op=0 or unrecognised op codes.

Reset
REQ-029 SHALL set, on reset=1 at posedge, state=IDLE, counter=0, busy=0, HI=0, LO=0 and pending registers=0.
REQ-030 SHALL let reset take priority over start and over mthi/mtlo.
REQ-031 SHALL abort any in-flight operation on reset with no commit; the first request may be accepted on the first edge with reset=0.

Structure
REQ-032 SHALL place in shared package mdu_pkg:
- the op encoding constants (MDU_NONE..MDU_MTLO);
- the state typedef (IDLE, RUN);
- the default latency constants.
REQ-033 SHALL be a single module with no sub-modules; the arithmetic is behavioural, computed at accept and held in pending registers.

Verification
REQ-034 SHALL verify mult of a=0xFFFFFFFE (-2) and b=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-035 SHALL verify multu of a=0xFFFFFFFF and b=2 -> after 5 cycles HI=0x00000001 and LO=0xFFFFFFFE.
REQ-036 SHALL verify div of a=-7 and b=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1).
- Follow-up: divu of 7 by 0 -> HI/LO unchanged after 10 busy cycles.
REQ-037 SHALL verify mthi a=0x12345678 then mflo/mfhi reads -> HI=0x12345678; out=0x12345678 with op=5, out=LO with op=6.
REQ-038 SHALL verify start of a second mult at cycle 2 of a div -> the second request is ignored, busy stays high exactly 10 cycles total and only the div result commits.
REQ-039 SHALL verify reset asserted at cycle 3 of a mult -> next cycle busy=0, HI=0 and LO=0, with no later commit.
